mdu_sequencer: RTL

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

---
 rtl/mdu_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/mdu_sequencer.sv
// Sequencer for a multi-cycle mul/div unit sitting in the EXE stage.
// It issues start/step/last to the datapath, and stalls the front end until the result is ready.
//   state  | meaning
//   IDLE   | no op in flight; start on op_valid_exe & ~kill
//   RUN    | datapath iterating, cnt counts down to 0
//   DONE   | result on EXE mux, held while ext_stall
module mdu_sequencer #(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned DIV_LATENCY = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid_exe,
  input  logic        op_is_div_exe,
  input  logic        kill,
  input  logic        ext_stall,
  output logic        mdu_start,
  output logic        mdu_step,
  output logic        mdu_last,
  output logic        result_sel_exe,
  output logic        stall_mdu,
  output logic        bubble_mem,
  output logic [31:0] stall_cycles
);

  localparam int unsigned MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       stall_cycles_q, stall_cycles_d;
  logic              start_req;

  assign start_req = op_valid_exe & ~kill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // kill outranks both the terminal count and a downstream stall
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d = S_RUN;
          cnt_d   = op_is_div_exe ? DIV_LOAD : MUL_LOAD;
        end
      end
      S_RUN: begin
        if (kill) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (kill) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (!ext_stall) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    stall_cycles_d = stall_cycles_q + {31'd0, stall_mdu};
  end

  always_comb begin
    mdu_start      = 1'b0;
    mdu_step       = 1'b0;
    mdu_last       = 1'b0;
    result_sel_exe = 1'b0;
    stall_mdu      = 1'b0;
    case (state_q)
      S_IDLE: begin
        mdu_start = start_req;
        stall_mdu = start_req;
      end
      S_RUN: begin
        mdu_step  = ~kill;
        mdu_last  = ~kill & (cnt_q == '0);
        stall_mdu = 1'b1;
      end
      S_DONE: begin
        result_sel_exe = ~kill;
      end
      default: ;
    endcase
  end

  assign bubble_mem   = stall_mdu;
  assign stall_cycles = stall_cycles_q;

endmodule
